ram_access_controller: RTL and testbench

//  Sequences and shares the byte-addressed data RAM (32-bit big-endian combinational read, one byte written per clock)

---
 rtl/mem_ctrl_pkg.sv | 39 +++
 rtl/ram_port_arbiter.sv | 59 +++++
 rtl/ram_access_controller.sv | 233 +++++++++++++++++++++++
 tb/tb_ram_access_controller.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared types and helpers for the RAM access controller.
//               access_size_t - encoding of the d_size request field
//               ctrl_state_t  - controller FSM states
//               size_to_nbytes() - byte count touched by an access size
// Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } access_size_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STORE = 2'd1,
        ACK   = 2'd2
    } ctrl_state_t;

    // Width of the fetch starvation counter (limit range is 1..15).
    localparam int C_STARVE_CNT_W = 4;

    // Number of bytes a store of the given size writes. SZ_BAD is rejected
    // before any RAM access, so its value only feeds the bounds arithmetic.
    function automatic logic [2:0] size_to_nbytes(input access_size_t size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage : mem_ctrl_pkg
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_port_arbiter
// Description : Grant selection between the fetch and data ports.
//               Data has priority; after STARVE_LIMIT consecutive data grants
//               with fetch pending, fetch is forced through once.
// Ports       : clock, reset_n   - clock / async active-low reset
//               arb_en           - grants allowed this cycle (FSM idle)
//               if_req, d_req    - port requests
//               grant_if/grant_d - one-hot (or none) grant, combinational
// Revision    : 1.0 - initial release
// ============================================================================
module ram_port_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic arb_en,
    input  logic if_req,
    input  logic d_req,
    output logic grant_if,
    output logic grant_d
);

    localparam logic [C_STARVE_CNT_W-1:0] C_LIMIT = C_STARVE_CNT_W'(STARVE_LIMIT);

    logic [C_STARVE_CNT_W-1:0] r_starve_cnt;
    logic                      w_force_if;

    assign w_force_if = (r_starve_cnt == C_LIMIT) && if_req && d_req;

    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (arb_en) begin
            if (d_req && !w_force_if) begin
                grant_d = 1'b1;
            end else if (if_req) begin
                grant_if = 1'b1;
            end
        end
    end

    // Counts data grants that overtook a pending fetch. Any cycle without a
    // fetch request, or any fetch grant, restarts the count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_starve_cnt <= '0;
        end else if (!if_req || grant_if) begin
            r_starve_cnt <= '0;
        end else if (grant_d && (r_starve_cnt != C_LIMIT)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

endmodule : ram_port_arbiter
`default_nettype wire

// File: rtl/ram_access_controller.sv
`default_nettype none
// ============================================================================
// Module      : ram_access_controller
// Description : Shares a byte-addressed RAM (32-bit big-endian combinational
//               read, one byte written per clock) between the instruction
//               fetch port and the load/store port. Arbitrates, bounds-checks,
//               splits half/word stores into byte writes and returns one
//               registered response per accepted request.
// Ports       : clock, reset_n            - clock / async active-low reset
//               if_req/if_addr            - fetch request (read only)
//               if_ready/if_rvalid/if_rdata/if_error - fetch handshake + resp
//               d_req/d_we/d_size/d_addr/d_wdata     - load/store request
//               d_ready/d_rvalid/d_rdata/d_error     - data handshake + resp
//               ram_*                     - RAM read/write interface
// Revision    : 1.0 - initial release
// ============================================================================
module ram_access_controller
    import mem_ctrl_pkg::*;
#(
    parameter int RAM_SIZE     = 32000,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    // fetch port
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_error,
    // load/store port
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_error,
    // RAM interface
    output logic [31:0] ram_read_address,
    output logic [31:0] ram_write_address,
    output logic [31:0] ram_write_data,
    output logic        ram_write_enable,
    input  logic [31:0] ram_read_data
);

    localparam logic [32:0] C_RAM_SIZE = 33'(RAM_SIZE);

    ctrl_state_t  r_state;
    ctrl_state_t  w_next_state;

    logic         w_grant_if;
    logic         w_grant_d;
    logic         w_arb_en;

    access_size_t w_size;
    logic [31:0]  w_addr;
    logic [2:0]   w_nbytes;
    logic [32:0]  w_last;
    logic         w_err;
    logic         w_do_read;
    logic         w_start_store;
    logic         w_store_done;
    logic [31:0]  w_wdata_aligned;

    logic [31:0]  r_rd_addr;
    logic [31:0]  r_st_addr;
    logic [31:0]  r_wdata_sh;
    logic [2:0]   r_nbytes;
    logic [1:0]   r_byte_idx;

    logic         r_if_rvalid;
    logic [31:0]  r_if_rdata;
    logic         r_if_error;
    logic         r_d_rvalid;
    logic [31:0]  r_d_rdata;
    logic         r_d_error;

    // ------------------------------------------------------------------
    // Arbitration: only in IDLE, and never while reset is asserted so that
    // the combinational ready outputs are 0 during reset.
    // ------------------------------------------------------------------
    assign w_arb_en = (r_state == IDLE) && reset_n;

    ram_port_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arbiter (
        .clock    (clock),
        .reset_n  (reset_n),
        .arb_en   (w_arb_en),
        .if_req   (if_req),
        .d_req    (d_req),
        .grant_if (w_grant_if),
        .grant_d  (w_grant_d)
    );

    assign if_ready = w_grant_if;
    assign d_ready  = w_grant_d;

    // ------------------------------------------------------------------
    // Bounds check of the granted request. 33-bit arithmetic so that an
    // address near 2^32 wrapping past zero is still seen as out of range.
    // ------------------------------------------------------------------
    assign w_size   = access_size_t'(d_size);
    assign w_addr   = w_grant_d ? d_addr : if_addr;
    assign w_nbytes = (w_grant_d && d_we) ? size_to_nbytes(w_size) : 3'd4;
    assign w_last   = {1'b0, w_addr} + 33'(w_nbytes) - 33'd1;
    assign w_err    = (w_last >= C_RAM_SIZE) || (w_grant_d && (w_size == SZ_BAD));

    assign w_do_read     = (w_grant_if || (w_grant_d && !d_we)) && !w_err;
    assign w_start_store = w_grant_d && d_we && !w_err;
    assign w_store_done  = (r_state == STORE) && ({1'b0, r_byte_idx} == (r_nbytes - 3'd1));

    // Left-justify the store payload so the first byte to write is always
    // in [31:23..24]; the sequencer then just shifts left one byte per write.
    always_comb begin
        w_wdata_aligned = d_wdata;
        case (w_size)
            SZ_BYTE: w_wdata_aligned = {d_wdata[7:0], 24'h000000};
            SZ_HALF: w_wdata_aligned = {d_wdata[15:0], 16'h0000};
            default: w_wdata_aligned = d_wdata;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and RAM write outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state      = r_state;
        ram_write_enable  = 1'b0;
        ram_write_address = 32'h0;
        ram_write_data    = 32'h0;
        case (r_state)
            IDLE: begin
                if (w_start_store) begin
                    w_next_state = STORE;
                end
            end
            STORE: begin
                ram_write_enable  = 1'b1;
                ram_write_address = r_st_addr + 32'(r_byte_idx);
                ram_write_data    = {24'h000000, r_wdata_sh[31:24]};
                if (w_store_done) begin
                    w_next_state = ACK;
                end
            end
            ACK: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // The read address follows the granted request during the accept cycle
    // and otherwise holds the last address actually read.
    assign ram_read_address = w_do_read ? w_addr : r_rd_addr;

    // ------------------------------------------------------------------
    // Datapath: store sequencer and registered responses
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_addr   <= '0;
            r_st_addr   <= '0;
            r_wdata_sh  <= '0;
            r_nbytes    <= '0;
            r_byte_idx  <= '0;
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_if_error  <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_d_rdata   <= '0;
            r_d_error   <= 1'b0;
        end else begin
            r_if_rvalid <= w_grant_if;
            // Loads and errored requests answer next cycle; stores answer
            // in ACK, i.e. the cycle after their last byte write.
            r_d_rvalid  <= (w_grant_d && !w_start_store) || w_store_done;

            if (w_grant_if) begin
                r_if_error <= w_err;
                r_if_rdata <= w_err ? 32'h0 : ram_read_data;
            end

            if (w_grant_d) begin
                r_d_error <= w_err;
                r_d_rdata <= (w_err || d_we) ? 32'h0 : ram_read_data;
            end else if (w_store_done) begin
                r_d_error <= 1'b0;
                r_d_rdata <= 32'h0;
            end

            if (w_do_read) begin
                r_rd_addr <= w_addr;
            end

            if (w_start_store) begin
                r_st_addr  <= d_addr;
                r_wdata_sh <= w_wdata_aligned;
                r_nbytes   <= w_nbytes;
                r_byte_idx <= 2'd0;
            end else if (r_state == STORE) begin
                r_wdata_sh <= {r_wdata_sh[23:0], 8'h00};
                r_byte_idx <= r_byte_idx + 2'd1;
            end
        end
    end

    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign if_error  = r_if_error;
    assign d_rvalid  = r_d_rvalid;
    assign d_rdata   = r_d_rdata;
    assign d_error   = r_d_error;

endmodule : ram_access_controller
`default_nettype wire

// File: tb/tb_ram_access_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_access_controller
// Description : Self-checking bench for ram_access_controller. Contains a
//               behavioural byte RAM, a reference memory image used to build
//               expected responses, and response scoreboards per port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_access_controller;

    localparam int RAM_SIZE     = 32000;
    localparam int STARVE_LIMIT = 4;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } resp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ready, if_rvalid, if_error;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [1:0]  d_size = 2'b10;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic        d_ready, d_rvalid, d_error;
    logic [31:0] d_rdata;
    logic [31:0] ram_read_address, ram_write_address, ram_write_data, ram_read_data;
    logic        ram_write_enable;

    // bench-side preload port into the RAM model
    logic        tb_we = 1'b0;
    logic [31:0] tb_wa = '0;
    logic [7:0]  tb_wd = '0;

    logic [7:0]  ram   [0:RAM_SIZE-1];
    logic [7:0]  model [0:RAM_SIZE-1];

    resp_t       d_q[$];
    resp_t       if_q[$];
    logic [39:0] wr_log[$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    ram_access_controller #(
        .RAM_SIZE     (RAM_SIZE),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .if_req            (if_req),
        .if_addr           (if_addr),
        .if_ready          (if_ready),
        .if_rvalid         (if_rvalid),
        .if_rdata          (if_rdata),
        .if_error          (if_error),
        .d_req             (d_req),
        .d_we              (d_we),
        .d_size            (d_size),
        .d_addr            (d_addr),
        .d_wdata           (d_wdata),
        .d_ready           (d_ready),
        .d_rvalid          (d_rvalid),
        .d_rdata           (d_rdata),
        .d_error           (d_error),
        .ram_read_address  (ram_read_address),
        .ram_write_address (ram_write_address),
        .ram_write_data    (ram_write_data),
        .ram_write_enable  (ram_write_enable),
        .ram_read_data     (ram_read_data)
    );

    // ---------------- RAM model ----------------
    always @(posedge clock) begin
        if (tb_we) begin
            ram[tb_wa[14:0]] <= tb_wd;
        end else if (ram_write_enable && (ram_write_address < RAM_SIZE)) begin
            ram[ram_write_address[14:0]] <= ram_write_data[7:0];
        end
    end

    always_comb begin
        ram_read_data = '0;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] a;
            a = ram_read_address + 32'(k);
            ram_read_data[31-8*k -: 8] = (a < RAM_SIZE) ? ram[a[14:0]] : 8'h00;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] addr);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] a;
            a = addr + 32'(k);
            w[31-8*k -: 8] = (a < RAM_SIZE) ? model[a[14:0]] : 8'h00;
        end
        return w;
    endfunction

    task automatic preload(input logic [31:0] addr, input logic [31:0] bytes4);
        for (int k = 0; k < 4; k++) begin
            tb_we = 1'b1;
            tb_wa = addr + 32'(k);
            tb_wd = bytes4[31-8*k -: 8];
            model[tb_wa[14:0]] = tb_wd;
            @(posedge clock);
            #1;
        end
        tb_we = 1'b0;
    endtask

    // One request on a port, scoreboarded, with response-latency check.
    task automatic txn(input bit is_if, input bit we, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata, input string tag);
        resp_t       e;
        int          nb, lat, exp_lat;
        logic [32:0] last;
        bit          err, got;
        nb   = (is_if || !we) ? 4 : ((size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4);
        last = {1'b0, addr} + 33'(nb) - 33'd1;
        err  = (last >= 33'(RAM_SIZE)) || (!is_if && (size == 2'b11));
        e.err  = err;
        e.data = (err || (we && !is_if)) ? 32'h0 : model_word(addr);
        @(posedge clock);
        #1;
        if (is_if) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            d_req = 1'b1; d_we = we; d_size = size; d_addr = addr; d_wdata = wdata;
        end
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clock);
            got = is_if ? if_ready : d_ready;
        end
        check({tag, "_accept"}, 32'(got), 32'd1);
        if (got) begin
            if (is_if) if_q.push_back(e);
            else       d_q.push_back(e);
            if (!is_if && we && !err) begin
                for (int k = 0; k < nb; k++) begin
                    logic [31:0] a;
                    a = addr + 32'(k);
                    model[a[14:0]] = wdata[8*(nb-1-k) +: 8];
                end
            end
        end
        @(posedge clock);
        #1;
        if_req = 1'b0;
        d_req  = 1'b0;
        if (got) begin
            @(negedge clock);
            lat = 1;
            while (!(is_if ? if_rvalid : d_rvalid) && lat < 20) begin
                @(negedge clock);
                lat++;
            end
            exp_lat = (!is_if && we && !err) ? nb + 1 : 1;
            check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        end
    endtask

    // ---------------- response monitor / scoreboard ----------------
    always @(negedge clock) begin
        resp_t e;
        if (reset_n) begin
            check("one_ready", 32'(d_ready && if_ready), 32'd0);
            if (ram_write_enable) wr_log.push_back({ram_write_address, ram_write_data[7:0]});
            if (d_rvalid) begin
                if (d_q.size() == 0) begin
                    check("d_unexpected_rvalid", 32'd1, 32'd0);
                end else begin
                    e = d_q.pop_front();
                    check("d_rdata", d_rdata, e.data);
                    check("d_error", 32'(d_error), 32'(e.err));
                end
            end
            if (if_rvalid) begin
                if (if_q.size() == 0) begin
                    check("if_unexpected_rvalid", 32'd1, 32'd0);
                end else begin
                    e = if_q.pop_front();
                    check("if_rdata", if_rdata, e.data);
                    check("if_error", 32'(if_error), 32'(e.err));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [1:0] gnt;
        logic       seen;

        // preload while the controller is held in reset
        @(posedge clock);
        #1;
        preload(32'h10, 32'hDEADBEEF);
        preload(32'h14, 32'h01020304);
        preload(32'h40, 32'h00556677);
        preload(32'(RAM_SIZE - 4), 32'hA1A2A3A4);
        @(negedge clock);
        check("reset_outputs", 32'(|{if_ready, if_rvalid, if_rdata, if_error, d_ready, d_rvalid,
                                     d_rdata, d_error, ram_read_address, ram_write_address,
                                     ram_write_data, ram_write_enable}), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // 1: load word
        txn(0, 0, 2'b10, 32'h10, 32'h0, "t1_load");

        // 2: word store, then reload
        wr_log.delete();
        txn(0, 1, 2'b10, 32'h20, 32'h11223344, "t2_store");
        check("t2_wr_count", 32'(wr_log.size()), 32'd4);
        if (wr_log.size() == 4) begin
            check("t2_wr0", 32'(wr_log[0]), {24'h000020, 8'h11});
            check("t2_wr1", 32'(wr_log[1]), {24'h000021, 8'h22});
            check("t2_wr2", 32'(wr_log[2]), {24'h000022, 8'h33});
            check("t2_wr3", 32'(wr_log[3]), {24'h000023, 8'h44});
        end
        txn(0, 0, 2'b10, 32'h20, 32'h0, "t2_reload");
        check("t2_model", model_word(32'h20), 32'h11223344);

        // 3: bounds
        wr_log.delete();
        txn(0, 0, 2'b10, 32'(RAM_SIZE - 3), 32'h0, "t3_load_oob");
        txn(1, 0, 2'b10, 32'hFFFFFFFE, 32'h0, "t3_fetch_wrap");
        check("t3_no_write", 32'(wr_log.size()), 32'd0);
        txn(0, 1, 2'b00, 32'(RAM_SIZE - 1), 32'h0000005A, "t3_store_last");
        check("t3_wr_count", 32'(wr_log.size()), 32'd1);
        if (wr_log.size() == 1) check("t3_wr0", wr_log[0][39:8], 32'(RAM_SIZE - 1));
        txn(0, 0, 2'b10, 32'(RAM_SIZE - 4), 32'h0, "t3_load_last");

        // 4: both ports saturated with reads
        @(posedge clock);
        #1;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h10;
        if_req = 1'b1; if_addr = 32'h14;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            gnt = {d_ready, if_ready};
            check($sformatf("t4_grant_%0d", i), 32'(gnt),
                  ((i % (STARVE_LIMIT + 1)) == STARVE_LIMIT) ? 32'd1 : 32'd2);
            if (d_ready)  d_q.push_back('{err: 1'b0, data: model_word(32'h10)});
            if (if_ready) if_q.push_back('{err: 1'b0, data: model_word(32'h14)});
        end
        @(posedge clock);
        #1;
        d_req = 1'b0; if_req = 1'b0;
        repeat (3) @(negedge clock);
        check("t4_d_drained", 32'(d_q.size()), 32'd0);
        check("t4_if_drained", 32'(if_q.size()), 32'd0);

        // 5: half store interrupted by reset after its first byte
        @(posedge clock);
        #1;
        d_req = 1'b1; d_we = 1'b1; d_size = 2'b01; d_addr = 32'h40; d_wdata = 32'h0000ABCD;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clock);
            seen = d_ready;
        end
        check("t5_accept", 32'(seen), 32'd1);
        @(posedge clock);
        #1;
        d_req = 1'b0;
        @(negedge clock);
        check("t5_we", 32'(ram_write_enable), 32'd1);
        check("t5_waddr", ram_write_address, 32'h40);
        check("t5_wdata", ram_write_data, 32'h000000AB);
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        d_req = 1'b1; if_req = 1'b1; if_addr = 32'h10;
        model[32'h40] = 8'hAB;
        @(negedge clock);
        check("t5_reset_outputs", 32'(|{if_ready, if_rvalid, if_rdata, if_error, d_ready, d_rvalid,
                                        d_rdata, d_error, ram_read_address, ram_write_address,
                                        ram_write_data, ram_write_enable}), 32'd0);
        @(posedge clock);
        #1;
        d_req = 1'b0; if_req = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clock);
            if (d_rvalid) seen = 1'b1;
        end
        check("t5_no_ack", 32'(seen), 32'd0);
        check("t5_mem40", 32'(ram[32'h40]), 32'h000000AB);
        check("t5_mem41", 32'(ram[32'h41]), 32'h00000055);
        txn(0, 0, 2'b10, 32'h40, 32'h0, "t5_reload");

        // 6: illegal size, then fetch contending with a store ack
        wr_log.delete();
        txn(0, 1, 2'b11, 32'h30, 32'h12345678, "t6_bad_size");
        check("t6_no_write", 32'(wr_log.size()), 32'd0);
        @(posedge clock);
        #1;
        d_req = 1'b1; d_we = 1'b1; d_size = 2'b00; d_addr = 32'h60; d_wdata = 32'h000000C3;
        @(negedge clock);
        check("t6_store_accept", 32'(d_ready), 32'd1);
        d_q.push_back('{err: 1'b0, data: 32'h0});
        model[32'h60] = 8'hC3;
        @(posedge clock);
        #1;
        d_req = 1'b0;
        if_req = 1'b1; if_addr = 32'h10;
        @(negedge clock);
        check("t6_if_ready_store", 32'(if_ready), 32'd0);
        @(negedge clock);
        check("t6_ack", 32'(d_rvalid), 32'd1);
        check("t6_if_ready_ack", 32'(if_ready), 32'd0);
        @(negedge clock);
        check("t6_if_ready_idle", 32'(if_ready), 32'd1);
        if (if_ready) if_q.push_back('{err: 1'b0, data: model_word(32'h10)});
        @(posedge clock);
        #1;
        if_req = 1'b0;
        repeat (3) @(negedge clock);

        check("end_d_q_empty", 32'(d_q.size()), 32'd0);
        check("end_if_q_empty", 32'(if_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ram_access_controller
`default_nettype wire
